// File: rtl/csr_file_mtrap_pkg.sv
// Machine-mode CSR file shared definitions:
// CSR addresses, cause codes, mstatus bits, Zicsr funct3 encodings.
package grande_risco_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MCNTINH  = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MVENDOR  = 12'hF11;
  localparam logic [11:0] CSR_MARCHID  = 12'hF12;
  localparam logic [11:0] CSR_MIMPID   = 12'hF13;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;

  localparam int MST_MIE  = 3;
  localparam int MST_MPIE = 7;
  localparam int IRQ_MSI  = 3;
  localparam int IRQ_MTI  = 7;
  localparam int IRQ_MEI  = 11;

  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  typedef enum logic [2:0] {
    CSR_RW  = 3'b001,
    CSR_RS  = 3'b010,
    CSR_RC  = 3'b011,
    CSR_RWI = 3'b101,
    CSR_RSI = 3'b110,
    CSR_RCI = 3'b111
  } csr_op_e;

endpackage

// File: rtl/csr_file_mtrap_if.sv
// CSR op request/response bus between the
// execute stage (master) and the CSR file (slave).
interface csr_file_mtrap_if;
  import grande_risco_csr_pkg::*;

  logic        csr_req;
  logic [2:0]  csr_func3;
  logic [4:0]  csr_src_idx;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_done;
  logic        csr_illegal;

  modport master (
    output csr_req, csr_func3, csr_src_idx,
    output csr_addr, csr_wdata,
    input  csr_rdata, csr_done, csr_illegal
  );

  modport slave (
    input  csr_req, csr_func3, csr_src_idx,
    input  csr_addr, csr_wdata,
    output csr_rdata, csr_done, csr_illegal
  );
endinterface

// File: rtl/csr_file_mtrap_counter.sv
// One W-bit hardware counter with independent
// 32-bit low / upper-part write ports.
module csr_counter
  import grande_risco_csr_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         inhibit,
  input  logic         wr_lo,
  input  logic         wr_hi,
  input  logic [31:0]  wdata,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] ONE = 1;

  logic [W-33:0] wd_hi;
  assign wd_hi = (W-32)'(wdata);

  // A write to either half replaces that half and suppresses the count.
  always_ff @(posedge clk) begin
    if (!rst_n)
      value <= '0;
    else if (wr_lo)
      value[31:0] <= wdata;
    else if (wr_hi)
      value[W-1:32] <= wd_hi;
    else if (inc && !inhibit)
      value <= value + ONE;
  end

endmodule

// File: rtl/csr_file_mtrap.sv
// Machine-mode CSR file: Zicsr ops, trap entry/MRET,
// interrupt pending/enable and hardware counters.
module csr_file_mtrap
  import grande_risco_csr_pkg::*;
#(
  parameter int          NUM_HPM     = 4,
  parameter int          CNT_WIDTH   = 64,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_1127,
  parameter bit          VECTORED_OK = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  csr_file_mtrap_if.slave   csr,
  input  logic              instret_inc,
  input  logic [(NUM_HPM>0 ? NUM_HPM : 1)-1:0] hpm_event,
  input  logic              trap_req,
  input  logic [31:0]       trap_cause,
  input  logic [31:0]       trap_pc,
  input  logic [31:0]       trap_val,
  input  logic              mret_req,
  output logic              redirect,
  output logic [31:0]       redirect_pc,
  input  logic              irq_ext,
  input  logic              irq_timer,
  input  logic              irq_soft,
  output logic              irq_take,
  output logic [31:0]       irq_cause
);

  localparam int NC = NUM_HPM + 2;
  localparam logic [31:0] MINH_MASK =
    32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3);

  logic        mst_mie, mst_mpie;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q;
  logic [31:0] mcause_q, mtval_q, minh_q, mip_q;
  logic [CNT_WIDTH-1:0] cnt_val [NC];
  logic [63:0] cnt_sel;
  logic [31:0] old_v, src, wv, mstatus_rd;
  logic [31:0] tvec_base, trap_tgt;
  logic [2:0]  pend;
  logic        known, wr_intent, bad_f3, illegal;
  logic        do_wr, cnt_rng, cnt_wr;
  logic [4:0]  k;
  csr_op_e     op;

  assign op = csr_op_e'(csr.csr_func3);
  assign k  = csr.csr_addr[4:0];

  assign src = csr.csr_func3[2] ? {27'b0, csr.csr_src_idx}
                                : csr.csr_wdata;
  assign wr_intent = (csr.csr_func3[1:0] == 2'b01)
                  || (csr.csr_src_idx != 5'd0);
  assign bad_f3 = (csr.csr_func3[1:0] == 2'b00);
  assign cnt_rng = (csr.csr_addr[11:8] == 4'hB
                 || csr.csr_addr[11:8] == 4'hC)
                 && csr.csr_addr[6:5] == 2'b00;

  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mst_mpie,
                       3'b0, mst_mie, 3'b0};

  // Unimplemented counter slots (and time) read as zero.
  always_comb begin
    cnt_sel = '0;
    if (k == 5'd0) cnt_sel = 64'(cnt_val[0]);
    if (k == 5'd2) cnt_sel = 64'(cnt_val[1]);
    for (int i = 0; i < NUM_HPM; i++)
      if (k == 5'(i + 3)) cnt_sel = 64'(cnt_val[i+2]);
  end

  always_comb begin
    known = 1'b1;
    old_v = '0;
    case (csr.csr_addr)
      CSR_MSTATUS:  old_v = mstatus_rd;
      CSR_MISA:     old_v = MISA_VALUE;
      CSR_MIE:      old_v = mie_q;
      CSR_MTVEC:    old_v = mtvec_q;
      CSR_MCNTINH:  old_v = minh_q;
      CSR_MSCRATCH: old_v = mscratch_q;
      CSR_MEPC:     old_v = mepc_q;
      CSR_MCAUSE:   old_v = mcause_q;
      CSR_MTVAL:    old_v = mtval_q;
      CSR_MIP:      old_v = mip_q;
      CSR_MVENDOR, CSR_MARCHID,
      CSR_MIMPID, CSR_MHARTID: old_v = '0;
      default: begin
        if (cnt_rng)
          old_v = csr.csr_addr[7] ? cnt_sel[63:32]
                                  : cnt_sel[31:0];
        else
          known = 1'b0;
      end
    endcase
  end

  always_comb begin
    wv = src;
    unique case (1'b1)
      (op == CSR_RS) || (op == CSR_RSI): wv = old_v | src;
      (op == CSR_RC) || (op == CSR_RCI): wv = old_v & ~src;
      default:                           wv = src;
    endcase
  end

  assign illegal = !known || bad_f3
                || (csr.csr_addr[11:10] == 2'b11 && wr_intent);
  assign do_wr = csr.csr_req && !illegal && wr_intent
              && !trap_req && !mret_req;
  assign cnt_wr = do_wr && csr.csr_addr[11:8] == 4'hB;

  assign tvec_base = {mtvec_q[31:2], 2'b00};
  assign trap_tgt = (mtvec_q[0] && trap_cause[31])
    ? tvec_base + {25'b0, trap_cause[4:0], 2'b00}
    : tvec_base;

  assign pend = {mip_q[IRQ_MEI] & mie_q[IRQ_MEI],
                 mip_q[IRQ_MTI] & mie_q[IRQ_MTI],
                 mip_q[IRQ_MSI] & mie_q[IRQ_MSI]};
  assign irq_take = (|pend) && mst_mie;
  assign irq_cause = pend[2] ? CAUSE_MEI :
                     pend[0] ? CAUSE_MSI :
                     pend[1] ? CAUSE_MTI : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mst_mie         <= 1'b0;
      mst_mpie        <= 1'b0;
      mie_q           <= '0;
      mtvec_q         <= '0;
      mscratch_q      <= '0;
      mepc_q          <= '0;
      mcause_q        <= '0;
      mtval_q         <= '0;
      minh_q          <= '0;
      mip_q           <= '0;
      csr.csr_done    <= 1'b0;
      csr.csr_rdata   <= '0;
      csr.csr_illegal <= 1'b0;
      redirect        <= 1'b0;
      redirect_pc     <= '0;
    end else begin
      mip_q <= {20'b0, irq_ext, 3'b0, irq_timer,
                3'b0, irq_soft, 3'b0};
      csr.csr_done    <= csr.csr_req;
      csr.csr_rdata   <= csr.csr_req ? old_v : '0;
      csr.csr_illegal <= csr.csr_req && illegal;
      redirect        <= trap_req || mret_req;
      redirect_pc     <= trap_req ? trap_tgt :
                         mret_req ? mepc_q : '0;
      if (trap_req) begin
        mepc_q   <= trap_pc & ~32'd1;
        mcause_q <= trap_cause;
        mtval_q  <= trap_val;
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else if (mret_req) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end else if (do_wr) begin
        case (csr.csr_addr)
          CSR_MSTATUS: begin
            mst_mie  <= wv[MST_MIE];
            mst_mpie <= wv[MST_MPIE];
          end
          CSR_MIE:      mie_q <= wv & MIE_MASK;
          CSR_MTVEC:    mtvec_q <= {wv[31:2], 1'b0,
                                    wv[0] & VECTORED_OK};
          CSR_MCNTINH:  minh_q <= wv & MINH_MASK;
          CSR_MSCRATCH: mscratch_q <= wv;
          CSR_MEPC:     mepc_q <= wv & ~32'd1;
          CSR_MCAUSE:   mcause_q <= wv;
          CSR_MTVAL:    mtval_q <= wv;
          default: ;
        endcase
      end
    end
  end

  // Slot K is both the address offset and the mcountinhibit bit.
  for (genvar j = 0; j < NC; j++) begin : g_cnt
    localparam int K = (j == 0) ? 0 : (j == 1) ? 2 : j + 1;
    logic inc;
    if (j == 0) begin : g_cy
      assign inc = 1'b1;
    end else if (j == 1) begin : g_ir
      assign inc = instret_inc;
    end else begin : g_hpm
      assign inc = hpm_event[j-2];
    end
    csr_counter #(.W(CNT_WIDTH)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (inc),
      .inhibit (minh_q[K]),
      .wr_lo   (cnt_wr && !csr.csr_addr[7] && k == 5'(K)),
      .wr_hi   (cnt_wr && csr.csr_addr[7] && k == 5'(K)),
      .wdata   (wv),
      .value   (cnt_val[j])
    );
  end

endmodule

// File: tb/tb_csr_file_mtrap.sv
// Table-driven bench for csr_file_mtrap with
// an rdata/illegal scoreboard and trap/counter sequences.
module tb_csr_file_mtrap;
  import grande_risco_csr_pkg::*;

  localparam logic [31:0] M = 32'hFFFF_FFFF;

  typedef struct {
    logic [2:0]  f3;
    logic [4:0]  idx;
    logic [11:0] a;
    logic [31:0] wd;
    logic [31:0] er;
    logic [31:0] m;
    logic        ill;
    string       nm;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic [31:0] m;
    logic        ill;
    logic        le;
    string       nm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instret_inc;
  logic [3:0]  hpm_event;
  logic        trap_req, mret_req;
  logic [31:0] trap_cause, trap_pc, trap_val;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        irq_ext, irq_timer, irq_soft;
  logic        irq_take;
  logic [31:0] irq_cause;

  int n_chk = 0;
  int n_fail = 0;
  vec_t tbl[$];
  exp_t exp_q[$];

  csr_file_mtrap_if bus ();

  csr_file_mtrap #(
    .NUM_HPM(4), .CNT_WIDTH(40),
    .MISA_VALUE(32'h4000_1127), .VECTORED_OK(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .csr(bus),
    .instret_inc(instret_inc), .hpm_event(hpm_event),
    .trap_req(trap_req), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_val(trap_val),
    .mret_req(mret_req), .redirect(redirect),
    .redirect_pc(redirect_pc), .irq_ext(irq_ext),
    .irq_timer(irq_timer), .irq_soft(irq_soft),
    .irq_take(irq_take), .irq_cause(irq_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.csr_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL stray_done: got 1 expected 0");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.le) begin
          n_chk++;
          if (bus.csr_rdata > e.r) begin
            n_fail++;
            $display("FAIL %s: got %h expected <= %h",
                     e.nm, bus.csr_rdata, e.r);
          end
        end else if (e.m != 32'h0) begin
          chk(e.nm, bus.csr_rdata & e.m, e.r & e.m);
        end
        chk({e.nm, "_ill"}, 32'(bus.csr_illegal), 32'(e.ill));
      end
    end
  end

  task automatic csr_op(input logic [2:0] f3, input logic [4:0] idx,
                        input logic [11:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic [31:0] m,
                        input logic ill, input logic le,
                        input logic tr, input string nm);
    exp_t e;
    int t;
    e.r = er; e.m = m; e.ill = ill; e.le = le; e.nm = nm;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.csr_req = 1'b1;
    bus.csr_func3 = f3;
    bus.csr_src_idx = idx;
    bus.csr_addr = a;
    bus.csr_wdata = wd;
    trap_req = tr;
    @(posedge clk); #1;
    bus.csr_req = 1'b0;
    trap_req = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 3) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: csr_done missing, expected 1", nm);
      exp_q.delete();
    end
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] er,
                    input string nm);
    csr_op(CSR_RS, 5'd0, a, 32'h0, er, M, 1'b0, 1'b0, 1'b0, nm);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] wd,
                    input logic [31:0] er, input string nm);
    csr_op(CSR_RW, 5'd1, a, wd, er, M, 1'b0, 1'b0, 1'b0, nm);
  endtask

  task automatic evt(input logic t, input logic m,
                     input logic [31:0] cause, input logic [31:0] pc,
                     input logic [31:0] val, input logic [31:0] epc,
                     input string nm);
    @(posedge clk); #1;
    trap_req = t; mret_req = m;
    trap_cause = cause; trap_pc = pc; trap_val = val;
    @(posedge clk); #1;
    trap_req = 1'b0; mret_req = 1'b0;
    @(negedge clk);
    chk({nm, "_redir"}, 32'(redirect), 32'd1);
    chk({nm, "_pc"}, redirect_pc, epc);
    @(negedge clk);
    chk({nm, "_pulse"}, 32'(redirect), 32'd0);
  endtask

  function automatic void add(logic [2:0] f3, logic [4:0] idx,
                              logic [11:0] a, logic [31:0] wd,
                              logic [31:0] er, logic [31:0] m,
                              logic ill, string nm);
    vec_t v;
    v.f3 = f3; v.idx = idx; v.a = a; v.wd = wd;
    v.er = er; v.m = m; v.ill = ill; v.nm = nm;
    tbl.push_back(v);
  endfunction

  initial begin
    add(CSR_RS, 0, CSR_MISA, 0, 32'h4000_1127, M, 0, "misa");
    add(CSR_RS, 0, CSR_MSTATUS, 0, 32'h1800, M, 0, "mst_rst");
    add(CSR_RW, 1, CSR_MSCRATCH, 32'hDEAD_BEEF, 0, M, 0, "scr_rw");
    add(CSR_RS, 1, CSR_MSCRATCH, 32'h0000_FFFF,
        32'hDEAD_BEEF, M, 0, "scr_rs");
    add(CSR_RC, 1, CSR_MSCRATCH, 32'hFF00_0000,
        32'hDEAD_FFFF, M, 0, "scr_rc");
    add(CSR_RS, 0, CSR_MSCRATCH, M, 32'h00AD_FFFF, M, 0, "scr_rd");
    add(CSR_RWI, 5'h15, CSR_MSCRATCH, 0,
        32'h00AD_FFFF, M, 0, "scr_rwi");
    add(CSR_RCI, 5'h01, CSR_MSCRATCH, 0, 32'h15, M, 0, "scr_rci");
    add(CSR_RSI, 5'h08, CSR_MSCRATCH, 0, 32'h14, M, 0, "scr_rsi");
    add(CSR_RS, 0, CSR_MSCRATCH, 0, 32'h1C, M, 0, "scr_rd2");
    add(CSR_RW, 1, 12'hC00, 0, 0, 0, 1, "cycle_rw");
    add(CSR_RS, 0, 12'hC00, 0, 0, 0, 0, "cycle_rs0");
    add(CSR_RW, 1, 12'h7C0, 0, 0, 0, 1, "unknown");
    add(3'b000, 1, CSR_MSCRATCH, M, 32'h1C, M, 1, "bad_f3");
    add(CSR_RS, 0, CSR_MSCRATCH, 0, 32'h1C, M, 0, "scr_keep");
    add(CSR_RW, 1, CSR_MEPC, 32'h201, 0, M, 0, "mepc_w");
    add(CSR_RS, 0, CSR_MEPC, 0, 32'h200, M, 0, "mepc_r");
    add(CSR_RW, 1, CSR_MTVEC, 32'h1003, 0, M, 0, "mtvec_w");
    add(CSR_RS, 0, CSR_MTVEC, 0, 32'h1001, M, 0, "mtvec_r");
    add(CSR_RW, 1, CSR_MIE, M, 0, M, 0, "mie_w");
    add(CSR_RS, 0, CSR_MIE, 0, 32'h888, M, 0, "mie_r");
    add(CSR_RW, 1, CSR_MSTATUS, M, 32'h1800, M, 0, "mst_w");
    add(CSR_RW, 1, CSR_MSTATUS, 0, 32'h1888, M, 0, "mst_r");
    add(CSR_RW, 1, CSR_MIE, 0, 32'h888, M, 0, "mie_clr");
    add(CSR_RSI, 0, CSR_MVENDOR, 0, 0, M, 0, "mvendor");
    add(CSR_RSI, 1, CSR_MVENDOR, 0, 0, 0, 1, "mvendor_w");
    add(CSR_RS, 0, CSR_MIP, 0, 0, M, 0, "mip0");
    add(CSR_RS, 0, 12'hC01, 0, 0, M, 0, "time");

    rst_n = 1'b0;
    bus.csr_req = 0; bus.csr_func3 = 0; bus.csr_src_idx = 0;
    bus.csr_addr = 0; bus.csr_wdata = 0;
    instret_inc = 0; hpm_event = 0;
    trap_req = 0; mret_req = 0;
    trap_cause = 0; trap_pc = 0; trap_val = 0;
    irq_ext = 0; irq_timer = 0; irq_soft = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_done", 32'(bus.csr_done), 0);
    chk("rst_redir", 32'(redirect), 0);
    chk("rst_take", 32'(irq_take), 0);
    chk("rst_cause", irq_cause, 0);
    chk("rst_rdata", bus.csr_rdata, 0);

    csr_op(CSR_RS, 0, 12'hB00, 0, 32'd20, M, 0, 1, 0, "mcycle");
    foreach (tbl[i])
      csr_op(tbl[i].f3, tbl[i].idx, tbl[i].a, tbl[i].wd,
             tbl[i].er, tbl[i].m, tbl[i].ill, 1'b0, 1'b0, tbl[i].nm);

    // vectored external interrupt entry
    wr(CSR_MTVEC, 32'h1001, 32'h1001, "mtvec_v");
    wr(CSR_MIE, 32'h800, 0, "mie_meie");
    wr(CSR_MSTATUS, 32'h8, 32'h1800, "mst_mie");
    irq_ext = 1'b1;
    repeat (2) @(negedge clk);
    chk("irq_take", 32'(irq_take), 1);
    chk("irq_cause", irq_cause, 32'h8000_000B);
    rd(CSR_MIP, 32'h800, "mip_ext");
    evt(1, 0, 32'h8000_000B, 32'h200, 0, 32'h102C, "trap");
    rd(CSR_MEPC, 32'h200, "trap_mepc");
    rd(CSR_MCAUSE, 32'h8000_000B, "trap_mcause");
    rd(CSR_MSTATUS, 32'h1880, "trap_mst");
    @(negedge clk);
    chk("irq_masked", 32'(irq_take), 0);
    irq_ext = 1'b0;

    evt(0, 1, 0, 0, 0, 32'h200, "mret");
    rd(CSR_MSTATUS, 32'h1888, "mret_mst");

    evt(1, 1, 32'h2, 32'h305, 32'h55, 32'h1000, "trap_mret");
    rd(CSR_MEPC, 32'h304, "tm_mepc");
    rd(CSR_MTVAL, 32'h55, "tm_mtval");
    rd(CSR_MSTATUS, 32'h1880, "tm_mst");

    trap_cause = 32'h2; trap_pc = 32'h400; trap_val = 0;
    csr_op(CSR_RW, 1, CSR_MSCRATCH, 32'hAAAA, 32'h1C, M,
           0, 0, 1, "csr_drop");
    rd(CSR_MSCRATCH, 32'h1C, "scr_after_trap");

    wr(CSR_MCNTINH, M, 0, "inh_w");
    rd(CSR_MCNTINH, 32'h7D, "inh_r");
    wr(CSR_MCNTINH, 32'h1, 32'h7D, "inh_cy");
    csr_op(CSR_RW, 1, 12'hB00, 32'h1234, 0, 0, 0, 0, 0, "cy_w");
    repeat (5) @(posedge clk);
    rd(12'hB00, 32'h1234, "cy_frozen");
    wr(12'hB00, M, 32'h1234, "cy_lo");
    wr(12'hB80, 0, 0, "cy_hi");
    wr(CSR_MCNTINH, 0, 32'h1, "inh_clr");
    repeat (3) @(posedge clk);
    rd(12'hB80, 32'h1, "cy_carry");
    rd(12'hC80, 32'h1, "cy_user_hi");

    wr(12'hB02, M, 0, "ir_lo");
    wr(12'hB82, M, 0, "ir_hi");
    rd(12'hB82, 32'hFF, "ir_hi_r");
    @(posedge clk); #1 instret_inc = 1'b1;
    @(posedge clk); #1 instret_inc = 1'b0;
    rd(12'hB02, 0, "ir_wrap_lo");
    rd(12'hB82, 0, "ir_wrap_hi");
    rd(12'hC02, 0, "ir_user");

    @(posedge clk); #1 hpm_event = 4'b0010;
    repeat (3) @(posedge clk);
    #1 hpm_event = 4'b0000;
    rd(12'hB04, 32'd3, "hpm1");
    rd(12'hB03, 32'd0, "hpm0");

    // reset lands on an in-flight CSR op and trap
    @(posedge clk); #1;
    bus.csr_req = 1'b1; bus.csr_func3 = CSR_RS;
    bus.csr_src_idx = 0; bus.csr_addr = CSR_MSCRATCH;
    trap_req = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    bus.csr_req = 1'b0; trap_req = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_done", 32'(bus.csr_done), 0);
      chk("rst_mid_redir", 32'(redirect), 0);
    end
    rd(CSR_MSCRATCH, 0, "scr_reset");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
